imem_fetch: RTL and testbench
=============================

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32: number of words, a power of two of at least 2.
REQ-003 SHALL have parameter ADDR_W, default 32: PC width in bits.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid (input, 1), req_ready (output, 1) and req_pc (input, ADDR_W): the fetch request, with req_pc as a byte address.
REQ-007 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_inst (output, DATA_W) and rsp_pc (output, ADDR_W): the fetch response.
REQ-008 SHALL have port rsp_fault, output, 2 bits: 00 = ok, 01 = misaligned, 10 = out of range, 11 = parity error.
REQ-009 SHALL have port flush, input, 1 bit: discard the held response.
REQ-010 SHALL have ports ld_en (input, 1), ld_addr (input, log2(DEPTH)) and ld_data (input, DATA_W): the program-load write port, indexed by word.
REQ-011 SHALL have port fault_cnt, output, 8 bits: saturating count of faulted responses.

Function
REQ-012 Request SHALL be accepted when req_valid and req_ready are both 1; req_ready SHALL equal (!rsp_valid || rsp_ready) && !flush.
REQ-013 An accepted request SHALL produce rsp_valid=1 on the following edge: fixed latency of 1 cycle.
REQ-014 A response SHALL hold rsp_inst, rsp_pc and rsp_fault stable while rsp_valid && !rsp_ready.
REQ-015 rsp_valid SHALL clear on an edge with rsp_ready=1 and no new accept; back-to-back accepts SHALL give one response per cycle.
REQ-016 Word index SHALL be req_pc[log2(DEPTH)+1:2].
REQ-017 req_pc[1:0]!=0 SHALL give fault 01; req_pc >= 4*DEPTH SHALL give fault 10; misaligned SHALL take priority over out of range.
REQ-018 Any faulted response SHALL drive rsp_inst to 0 (NOP).
REQ-019 ld_en=1 SHALL write ld_data to memory at ld_addr on the edge.
REQ-020 When a load and an accept target the same word in the same cycle, the response SHALL carry the old data.
REQ-021 flush=1 SHALL clear rsp_valid on the edge and block accept that cycle; flush SHALL dominate rsp_ready.
REQ-022 fault_cnt SHALL increment once per accepted faulted request and saturate at 255.
REQ-023 Memory contents SHALL initialise to all zeros at time 0 and SHALL change only through the load port.

Reset
REQ-024 reset_n=0 SHALL immediately force rsp_valid=0, rsp_inst=0, rsp_pc=0, rsp_fault=00 and fault_cnt=0.
REQ-025 req_ready SHALL read 0 while reset_n=0.
REQ-026 Reset SHALL NOT alter memory contents.
REQ-027 Reset asserted mid-response SHALL drop the response with no replay after reset release.

Configuration
REQ-028 Macro IMEM_PARITY_EN defined SHALL store an even-parity bit per word, computed on load.
REQ-029 With IMEM_PARITY_EN defined, the block SHALL add input ld_par_flip (1 bit), which stores inverted parity for error injection.
REQ-030 With IMEM_PARITY_EN defined, a read with parity mismatch on an otherwise valid address SHALL give fault 11 with rsp_inst=0.
REQ-031 Without IMEM_PARITY_EN, the block SHALL have no parity storage, no ld_par_flip port, and SHALL never produce fault 11.

Verification
REQ-032 Load word 3 = 0x2002000A, then request pc=0x0C -> next cycle rsp_valid=1, rsp_inst=0x2002000A, rsp_pc=0x0C, rsp_fault=00.
REQ-033 Request pc=0x06 -> rsp_fault=01, rsp_inst=0, fault_cnt=1; request pc=0x80 with DEPTH=32 -> rsp_fault=10, fault_cnt=2.
REQ-034 Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response stable, one accept after rsp_ready=1.
REQ-035 Same-cycle load of word 5 = 0xFFFFFFFF and request pc=0x14 -> response gives old value 0; a repeat request -> 0xFFFFFFFF.
REQ-036 Assert flush, then assert reset_n=0 mid-response -> rsp_valid=0 immediately; with IMEM_PARITY_EN, loading with ld_par_flip=1 then reading -> rsp_fault=11.

Source files
------------

// File: rtl/imem_fetch.sv
// imem_fetch: word-organised instruction memory with a one-deep fetch
// response register.
//
// A request (req_valid/req_ready, byte address req_pc) is accepted when the
// response slot is free or is being drained this cycle. One cycle after the
// accept, the response appears on rsp_valid/rsp_inst/rsp_pc/rsp_fault. The
// response holds until rsp_ready or flush is seen. Faulted responses return a
// NOP (all-zero word) and bump a saturating 8-bit fault counter.
//
// Ports
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake
//   req_pc                  : request byte address
//   rsp_valid/rsp_ready     : response handshake
//   rsp_inst, rsp_pc        : fetched word and the address it came from
//   rsp_fault               : 00 ok, 01 misaligned, 10 out of range, 11 parity
//   flush                   : drop the held response, block accept this cycle
//   ld_en/ld_addr/ld_data   : program-load write port (word indexed)
//   ld_par_flip             : (IMEM_PARITY_EN only) store inverted parity
//   fault_cnt               : saturating count of faulted responses
//
// Build option
//   IMEM_PARITY_EN : keeps an even-parity bit per word, checked on read.
module imem_fetch #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_pc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_inst,
  output logic [ADDR_W-1:0]        rsp_pc,
  output logic [1:0]               rsp_fault,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
`ifdef IMEM_PARITY_EN
  input  logic                     ld_par_flip,
`endif
  output logic [7:0]               fault_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so 4*DEPTH is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W+1)'(DEPTH) << 2;

  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10,
    FAULT_PARITY   = 2'b11
  } fault_e;

  // Storage: zero at power-up, not touched by reset.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
`ifdef IMEM_PARITY_EN
  logic              par_q [DEPTH] = '{default: 1'b0};
`endif

  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;
  fault_e            rd_fault;
  logic              accept;

  logic              rsp_valid_d, rsp_valid_q;
  logic [DATA_W-1:0] rsp_inst_d,  rsp_inst_q;
  logic [ADDR_W-1:0] rsp_pc_d,    rsp_pc_q;
  fault_e            rsp_fault_d, rsp_fault_q;
  logic [7:0]        fault_cnt_d, fault_cnt_q;

  // Address decode and fault classification; misaligned wins over range,
  // and parity is only considered for an otherwise valid address.
  always_comb begin
    rd_idx   = req_pc[IDX_W+1:2];
    rd_word  = mem_q[rd_idx];
    rd_fault = FAULT_OK;
    if (req_pc[1:0] != 2'b00) begin
      rd_fault = FAULT_MISALIGN;
    end else if ({1'b0, req_pc} >= PC_LIMIT) begin
      rd_fault = FAULT_RANGE;
    end
`ifdef IMEM_PARITY_EN
    else if ((^rd_word) != par_q[rd_idx]) begin
      rd_fault = FAULT_PARITY;
    end
`endif
  end

  // reset_n gates ready so nothing is accepted while reset is held.
  always_comb begin
    req_ready = reset_n && (!rsp_valid_q || rsp_ready) && !flush;
    accept    = req_valid && req_ready;
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_inst_d  = rsp_inst_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_fault_d = rsp_fault_q;
    fault_cnt_d = fault_cnt_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_inst_d  = (rd_fault == FAULT_OK) ? rd_word : '0;
      rsp_pc_d    = req_pc;
      rsp_fault_d = rd_fault;
      if (rd_fault != FAULT_OK && fault_cnt_q != 8'hFF) begin
        fault_cnt_d = fault_cnt_q + 8'd1;
      end
    end else if (flush || rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= '0;
      rsp_pc_q    <= '0;
      rsp_fault_q <= FAULT_OK;
      fault_cnt_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_inst_q  <= rsp_inst_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_fault_q <= rsp_fault_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  // Write port. A same-cycle read of the same word sees the pre-edge data
  // because the response register samples rd_word before this update lands.
  always_ff @(posedge clock) begin
    if (ld_en) begin
      mem_q[ld_addr] <= ld_data;
`ifdef IMEM_PARITY_EN
      par_q[ld_addr] <= (^ld_data) ^ ld_par_flip;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_inst  = rsp_inst_q;
  assign rsp_pc    = rsp_pc_q;
  assign rsp_fault = rsp_fault_q;
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: directed scenarios plus a randomized
// run, all compared against a behavioural model of memory contents and the
// response slot. Parity scenarios are compiled in with IMEM_PARITY_EN.
module tb_imem_fetch;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_pc;
  logic [1:0]  rsp_fault;
  logic        flush = 1'b0;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        par_flip = 1'b0;
  logic [7:0]  fault_cnt;

  always #5 clock = ~clock;

  imem_fetch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_pc    (rsp_pc),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
`ifdef IMEM_PARITY_EN
    .ld_par_flip (par_flip),
`endif
    .fault_cnt (fault_cnt)
  );

  // Behavioural model
  logic [31:0] m_mem  [DEPTH];
  bit          m_flip [DEPTH];
  logic        exp_valid;
  logic [31:0] exp_inst;
  logic [31:0] exp_pc;
  logic [1:0]  exp_fault;
  int          exp_cnt;
  logic        exp_ready;
  logic        obs_ready;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [1:0] ref_fault(input logic [31:0] pc);
    if (pc % 4 != 0)        return 2'b01;
    if (pc >= 4 * DEPTH)    return 2'b10;
    if (m_flip[pc / 4])     return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_inst  = '0;
    exp_pc    = '0;
    exp_fault = 2'b00;
    exp_cnt   = 0;
  endtask

  task automatic drive(input logic rv, input logic [31:0] pc, input logic rr,
                       input logic fl, input logic le, input int la,
                       input logic [31:0] ld, input logic pf);
    req_valid = rv;
    req_pc    = pc;
    rsp_ready = rr;
    flush     = fl;
    ld_en     = le;
    ld_addr   = la[4:0];
    ld_data   = ld;
    par_flip  = pf;
  endtask

  // Called at a falling edge after drive(): samples req_ready mid-cycle,
  // updates the model for the coming rising edge, returns at the next
  // falling edge.
  task automatic advance();
    logic       acc;
    logic [1:0] f;
    exp_ready = reset_n && (!exp_valid || rsp_ready) && !flush;
    #2 obs_ready = req_ready;
    acc = req_valid && exp_ready;
    if (acc) begin
      f         = ref_fault(req_pc);
      exp_valid = 1'b1;
      exp_pc    = req_pc;
      exp_fault = f;
      exp_inst  = (f == 2'b00) ? m_mem[req_pc / 4] : 32'h0;
      if (f != 2'b00 && exp_cnt < 255) exp_cnt++;
    end else if (flush || rsp_ready) begin
      exp_valid = 1'b0;
    end
    if (ld_en) begin
      m_mem[ld_addr]  = ld_data;
      m_flip[ld_addr] = par_flip;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", rsp_inst); else n_pass++;
    n_checks++; if (rsp_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", rsp_pc); else n_pass++;
    n_checks++; if (rsp_fault !== 2'b00) $display("FAIL reset_fault: got %b want 00", rsp_fault); else n_pass++;
    n_checks++; if (fault_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", fault_cnt); else n_pass++;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready); else n_pass++;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_load_fetch();
    drive(0, 0, 1, 0, 1, 3, 32'h2002000A, 0); advance();
    drive(1, 32'h0C, 1, 0, 0, 0, 0, 0); advance();
    n_checks++; if (obs_ready !== 1'b1) $display("FAIL fetch_ready: got %b want 1", obs_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL fetch_valid: got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_inst !== 32'h2002000A) $display("FAIL fetch_inst: got %h want 2002000a", rsp_inst); else n_pass++;
    n_checks++; if (rsp_pc !== 32'h0C) $display("FAIL fetch_pc: got %h want 0000000c", rsp_pc); else n_pass++;
    n_checks++; if (rsp_fault !== 2'b00) $display("FAIL fetch_fault: got %b want 00", rsp_fault); else n_pass++;
    drive(0, 0, 1, 0, 0, 0, 0, 0); advance();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL fetch_drain: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_faults();
    drive(1, 32'h06, 1, 0, 0, 0, 0, 0); advance();
    n_checks++; if (rsp_fault !== 2'b01) $display("FAIL misalign_fault: got %b want 01", rsp_fault); else n_pass++;
    n_checks++; if (rsp_inst !== 32'h0) $display("FAIL misalign_inst: got %h want 0", rsp_inst); else n_pass++;
    n_checks++; if (fault_cnt !== 8'd1) $display("FAIL misalign_cnt: got %0d want 1", fault_cnt); else n_pass++;
    drive(1, 32'h80, 1, 0, 0, 0, 0, 0); advance();
    n_checks++; if (rsp_fault !== 2'b10) $display("FAIL range_fault: got %b want 10", rsp_fault); else n_pass++;
    n_checks++; if (fault_cnt !== 8'd2) $display("FAIL range_cnt: got %0d want 2", fault_cnt); else n_pass++;
    drive(1, 32'h7C, 1, 0, 0, 0, 0, 0); advance();
    n_checks++; if (rsp_fault !== 2'b00) $display("FAIL last_word_fault: got %b want 00", rsp_fault); else n_pass++;
    drive(1, 32'h82, 1, 0, 0, 0, 0, 0); advance();
    n_checks++; if (rsp_fault !== 2'b01) $display("FAIL priority_fault: got %b want 01", rsp_fault); else n_pass++;
    n_checks++; if (fault_cnt !== 8'd3) $display("FAIL priority_cnt: got %0d want 3", fault_cnt); else n_pass++;
    drive(0, 0, 1, 0, 0, 0, 0, 0); advance();
  endtask

  task automatic test_backpressure();
    drive(1, 32'h0C, 0, 0, 0, 0, 0, 0); advance();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h10, 0, 0, 0, 0, 0, 0); advance();
      n_checks++; if (obs_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b want 0", i, obs_ready); else n_pass++;
      n_checks++;
      if ({rsp_valid, rsp_inst, rsp_pc, rsp_fault} !== {1'b1, 32'h2002000A, 32'h0C, 2'b00})
        $display("FAIL stall_hold[%0d]: got %b/%h/%h/%b want 1/2002000a/0000000c/00", i, rsp_valid, rsp_inst, rsp_pc, rsp_fault);
      else n_pass++;
    end
    drive(1, 32'h10, 1, 0, 0, 0, 0, 0); advance();
    n_checks++; if (obs_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", obs_ready); else n_pass++;
    n_checks++; if (rsp_pc !== 32'h10) $display("FAIL release_pc: got %h want 00000010", rsp_pc); else n_pass++;
    drive(0, 0, 1, 0, 0, 0, 0, 0); advance();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_accept: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_load_collision();
    drive(1, 32'h14, 1, 0, 1, 5, 32'hFFFFFFFF, 0); advance();
    n_checks++; if (rsp_inst !== 32'h0) $display("FAIL collide_old: got %h want 0", rsp_inst); else n_pass++;
    drive(1, 32'h14, 1, 0, 0, 0, 0, 0); advance();
    n_checks++; if (rsp_inst !== 32'hFFFFFFFF) $display("FAIL collide_new: got %h want ffffffff", rsp_inst); else n_pass++;
    drive(0, 0, 1, 0, 0, 0, 0, 0); advance();
  endtask

  task automatic test_flush_reset();
    drive(1, 32'h0C, 0, 0, 0, 0, 0, 0); advance();
    drive(1, 32'h14, 1, 1, 0, 0, 0, 0); advance();
    n_checks++; if (obs_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", obs_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_pc !== 32'h0C) $display("FAIL flush_noaccept: got %h want 0000000c", rsp_pc); else n_pass++;
    drive(1, 32'h0C, 0, 0, 0, 0, 0, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL midrsp_reset_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_inst !== 32'h0) $display("FAIL midrsp_reset_inst: got %h want 0", rsp_inst); else n_pass++;
    n_checks++; if (fault_cnt !== 8'd0) $display("FAIL midrsp_reset_cnt: got %0d want 0", fault_cnt); else n_pass++;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0); advance();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL no_replay: got %b want 0", rsp_valid); else n_pass++;
    drive(1, 32'h0C, 1, 0, 0, 0, 0, 0); advance();
    n_checks++; if (rsp_inst !== 32'h2002000A) $display("FAIL mem_survives_reset: got %h want 2002000a", rsp_inst); else n_pass++;
    drive(0, 0, 1, 0, 0, 0, 0, 0); advance();
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    drive(0, 0, 1, 0, 1, 7, 32'h1234_5678, 1); advance();
    drive(1, 32'h1C, 1, 0, 0, 0, 0, 0); advance();
    n_checks++; if (rsp_fault !== 2'b11) $display("FAIL parity_fault: got %b want 11", rsp_fault); else n_pass++;
    n_checks++; if (rsp_inst !== 32'h0) $display("FAIL parity_inst: got %h want 0", rsp_inst); else n_pass++;
    drive(0, 0, 1, 0, 1, 7, 32'h1234_5678, 0); advance();
    drive(1, 32'h1C, 1, 0, 0, 0, 0, 0); advance();
    n_checks++; if (rsp_fault !== 2'b00) $display("FAIL parity_clean: got %b want 00", rsp_fault); else n_pass++;
    drive(0, 0, 1, 0, 0, 0, 0, 0); advance();
  endtask
`endif

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      drive(1, 32'h01, 1, 0, 0, 0, 0, 0); advance();
    end
    n_checks++; if (fault_cnt !== 8'd255) $display("FAIL saturate_cnt: got %0d want 255", fault_cnt); else n_pass++;
    n_checks++; if (fault_cnt !== exp_cnt[7:0]) $display("FAIL saturate_model: got %0d want %0d", fault_cnt, exp_cnt); else n_pass++;
    drive(0, 0, 1, 0, 0, 0, 0, 0); advance();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int          sel, la;
    logic        le, pf;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (sel == 7) pc = 32'($urandom_range(0, 200));
      else if (sel == 8) pc = $urandom;
      else               pc = 32'($urandom_range(4 * DEPTH, 8 * DEPTH)) & ~32'h3;
      le = ($urandom_range(0, 2) == 0);
      la = ($urandom_range(0, 3) == 0) ? int'(pc[6:2]) : int'($urandom_range(0, DEPTH - 1));
      pf = 1'b0;
`ifdef IMEM_PARITY_EN
      pf = ($urandom_range(0, 3) == 0);
`endif
      drive($urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) != 0,
            $urandom_range(0, 11) == 0, le, la, $urandom, pf);
      advance();
      n_checks++;
      if (obs_ready !== exp_ready) $display("FAIL rand_ready[%0d]: got %b want %b", i, obs_ready, exp_ready);
      else n_pass++;
      n_checks++;
      if ({rsp_valid, rsp_inst, rsp_pc, rsp_fault, fault_cnt} !== {exp_valid, exp_inst, exp_pc, exp_fault, exp_cnt[7:0]})
        $display("FAIL rand_rsp[%0d]: got v=%b i=%h pc=%h f=%b c=%0d want v=%b i=%h pc=%h f=%b c=%0d",
                 i, rsp_valid, rsp_inst, rsp_pc, rsp_fault, fault_cnt,
                 exp_valid, exp_inst, exp_pc, exp_fault, exp_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_flip[i] = 1'b0;
    end
    model_reset();
    test_reset();
    test_load_fetch();
    test_faults();
    test_backpressure();
    test_load_collision();
    test_flush_reset();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
